// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;
  localparam int UART_DATA_W             = 8;
  localparam int UART_DEF_NUM_REQ        = 4;
  localparam int UART_DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK  = 2'd1,
    ST_DRAIN = 2'd2
  } uart_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = UART_DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_req
);
  int w_idx;

  // Scan from farthest offset down so the candidate nearest i_ptr wins.
  always_comb begin
    o_winner = '0;
    w_idx    = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = (int'(i_ptr) + i) % NUM_REQ;
      if (i_req[w_idx]) o_winner = w_idx[IDX_W-1:0];
    end
  end

  assign o_any_req = |i_req;
endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter feeding one UART transmitter byte stream.
// Optional idle-lock release compiled in with UART_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = UART_DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = UART_DEF_TIMEOUT_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][UART_DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                    req_last,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [UART_DATA_W-1:0]                tx_data,
  output logic                                  tx_valid,
  input  logic                                  tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]            grant_id,
  output logic                                  busy,
  output logic                                  timeout
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arb: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  uart_arb_state_t        r_state;
  logic [IDX_W-1:0]       r_ptr;
  logic [IDX_W-1:0]       r_grant;
  logic                   r_tx_valid;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic                   r_last_q;

  logic [IDX_W-1:0] w_winner;
  logic [IDX_W-1:0] w_next_ptr;
  logic             w_any;
  logic             w_accept;
  logic             w_tx_hs;
  logic             w_tmo_fire;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req     (req_valid),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any)
  );

  assign w_next_ptr = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
  // Single-entry buffer: the owner may only hand over a byte while it is empty.
  assign w_accept   = (r_state == ST_LOCK) && req_valid[r_grant] && !r_tx_valid;
  assign w_tx_hs    = r_tx_valid && tx_ready;

  always_comb begin
    req_ready = '0;
    if (r_state == ST_LOCK) req_ready[r_grant] = !r_tx_valid;
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_timeout;
  logic             w_lock_idle;

  assign w_lock_idle = (r_state == ST_LOCK) && !req_valid[r_grant] && !r_tx_valid;
  assign w_tmo_fire  = w_lock_idle && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_tmo_fire;
      if (!w_lock_idle || w_tmo_fire) r_tmo_cnt <= '0;
      else                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_tmo_fire = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_last_q   <= 1'b0;
    end else begin
      if (w_tx_hs) r_tx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_winner;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_accept) begin
            r_tx_data  <= req_data[r_grant];
            r_tx_valid <= 1'b1;
            r_last_q   <= req_last[r_grant];
            if (req_last[r_grant]) r_state <= ST_DRAIN;
          end else if (w_tmo_fire) begin
            r_ptr   <= w_next_ptr;
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_tx_hs && r_last_q) begin
            r_ptr   <= w_next_ptr;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign grant_id = r_grant;
  assign busy     = (r_state != ST_IDLE);
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, idle-lock release limit; used only with UART_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  NUM_REQ x 8  per-requester byte.
REQ-007 SHALL have port req_last  input  NUM_REQ  byte is last of the requester's packet.
REQ-008 SHALL have port req_ready  output  NUM_REQ  byte accepted when valid and ready are both high.
REQ-009 SHALL have port tx_data  output  8  byte to the UART transmitter data input.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid toward the transmitter.
REQ-011 SHALL have port tx_ready  input  1  transmitter ready; byte consumed when tx_valid and tx_ready are both high.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_REQ)  requester currently holding the lock.
REQ-013 SHALL have port busy  output  1  high while in LOCK or DRAIN.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse on forced lock release.

Function
REQ-015 SHALL implement states IDLE, LOCK, DRAIN.
REQ-016 In IDLE with any req_valid high at edge t, SHALL pick the winner round-robin from ptr (ptr first, then ascending with wrap), load grant_id, and enter LOCK at t+1; no byte accepted in IDLE.
REQ-017 In LOCK, req_ready[grant_id] SHALL equal !tx_valid; all other req_ready bits SHALL be 0.
REQ-018 On the accept edge SHALL register req_data[grant_id] into tx_data, set tx_valid, and store req_last[grant_id] in last_q; tx_valid is high the next cycle, so accept-to-tx_valid latency is 1 cycle.
REQ-019 tx_data and tx_valid SHALL be held stable until the tx handshake; tx_valid clears on the handshake edge unless a new byte is accepted on that same edge.
REQ-020 Accepting a byte with req_last=1 SHALL enter DRAIN; in DRAIN all req_ready bits are 0.
REQ-021 On the tx handshake in DRAIN SHALL set ptr to grant_id+1 (mod NUM_REQ) and enter IDLE.
REQ-022 Maximum throughput SHALL be one byte per two cycles when tx_ready is held high; tx_ready low stalls with no data loss.
REQ-023 Deassertion of req_valid by the granted requester SHALL NOT release the lock, except as given in REQ-030.
REQ-024 A requester SHALL never be granted twice in a row while another requester is valid in IDLE.

Reset
REQ-025 Assertion of rst SHALL asynchronously set state=IDLE, ptr=0, grant_id=0, tx_valid=0, tx_data=0, last_q=0, busy=0, timeout=0, req_ready=0, and timeout counter=0.
REQ-026 Reset asserted mid-packet SHALL discard the buffered byte; after release, arbitration restarts from requester 0.

Configuration
REQ-027 Macro UART_ARB_TIMEOUT_EN SHALL compile in the lock-timeout feature.
REQ-028 Without the macro, timeout SHALL be tied to 0, no counter SHALL exist, and a lock is released only via a last byte.
REQ-029 With the macro, a counter SHALL increment each LOCK cycle with req_valid[grant_id]=0 and tx_valid=0, and clear on any accept or state change.
REQ-030 With the macro, reaching TIMEOUT_CYCLES SHALL pulse timeout for one cycle, set ptr=grant_id+1, and return to IDLE.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum (uart_arb_state_t), UART_DATA_W=8, and the default NUM_REQ and TIMEOUT_CYCLES constants.
REQ-032 Round-robin selection SHALL live in sub-module rr_arbiter (inputs: request vector, ptr; outputs: winner index, any_req), combinational.

Verification
REQ-033 Single requester: req0 sends 0xA5, 0x3C (last), tx_ready=1 -> tx_data sequence 0xA5, 0x3C, then IDLE, ptr=1.
REQ-034 Contention: req0, req2 and req3 valid with 1-byte packets, ptr=0 -> grant order 0, 2, 3; req2 is stalled without loss.
REQ-035 Backpressure: tx_ready low 20 cycles with tx_valid high, tx_data=0x55 -> tx_data stable, req_ready[grant_id]=0 throughout.
REQ-036 Packet lock: req1 sends 3-byte packet while req0 valid -> req0 not granted until after req1's last byte handshakes.
REQ-037 Reset mid-packet: rst pulsed while tx_valid=1 -> all outputs at reset values the same cycle; next grant goes to lowest valid index.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=8): granted req1 drops valid after 1 byte -> timeout pulses after 8 idle cycles and req2 is granted next.
